// File: rtl/int_ctrl_gen.sv
// Interrupt controller: per-channel synchroniser, debounce, trigger select and sticky status.
// Outputs a registered interrupt line and the lowest pending channel id.
module int_ctrl_gen #(
    parameter int N_IN        = 13,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int ID_W        = 5
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [N_IN-1:0]   in_raw,
    input  logic [N_IN-1:0]   int_ena,
    input  logic [2*N_IN-1:0] int_mode,
    input  logic [N_IN-1:0]   int_clr,
    input  logic [N_IN-1:0]   int_set,
    output logic [N_IN-1:0]   int_sts,
    output logic [N_IN-1:0]   in_level,
    output logic [ID_W-1:0]   int_id,
    output logic              int_any,
    output logic              interrupt
);

    localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    logic interrupt_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   sync_w;
            logic                   level_q, level_d;
            logic                   sts_q, sts_d;
            logic                   edge_evt, lvl_evt;
            logic [1:0]             mode_w;

            assign sync_w = sync_q[SYNC_STAGES-1];
            assign mode_w = int_mode[2*gi +: 2];

            if (DEB_CYCLES == 0) begin : g_nodeb
                assign level_d = sync_w;
            end else begin : g_deb
                logic [CNT_W-1:0] cnt_q, cnt_d;

                // Accept the new level only after DEB_CYCLES consecutive differing samples.
                always_comb begin
                    level_d = level_q;
                    cnt_d   = '0;
                    if (sync_w != level_q) begin
                        if (cnt_q == CNT_W'(DEB_CYCLES - 1))
                            level_d = sync_w;
                        else
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                always_ff @(posedge clk) begin
                    if (!res_n) cnt_q <= '0;
                    else        cnt_q <= cnt_d;
                end
            end

            always_comb begin
                edge_evt = 1'b0;
                lvl_evt  = 1'b0;
                case (mode_w)
                    2'b00:   edge_evt = level_d & ~level_q;
                    2'b01:   edge_evt = ~level_d & level_q;
                    2'b10:   edge_evt = level_d ^ level_q;
                    default: lvl_evt  = level_d;
                endcase
            end

            // A held level yields to a clear for one cycle so software sees the drop,
            // then re-asserts; edge events and software set win over a clear.
            always_comb begin
                sts_d = sts_q;
                if (!int_ena[gi])
                    sts_d = 1'b0;
                else if (edge_evt || int_set[gi])
                    sts_d = 1'b1;
                else if (int_clr[gi])
                    sts_d = 1'b0;
                else if (lvl_evt)
                    sts_d = 1'b1;
            end

            always_ff @(posedge clk) begin
                if (!res_n) begin
                    sync_q  <= '0;
                    level_q <= 1'b0;
                    sts_q   <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[SYNC_STAGES-2:0], in_raw[gi]};
                    level_q <= level_d;
                    sts_q   <= sts_d;
                end
            end

            assign int_sts[gi]  = sts_q;
            assign in_level[gi] = level_q;
        end
    endgenerate

    always_comb begin
        int_id = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (int_sts[i]) int_id = ID_W'(i);
        end
    end

    assign int_any = |int_sts;

    always_ff @(posedge clk) begin
        if (!res_n) interrupt_q <= 1'b0;
        else        interrupt_q <= |int_sts;
    end

    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_int_ctrl_gen.sv
// Self-checking bench for int_ctrl_gen: table-driven trigger vectors plus hand-written
// corner sequences; expectations are scheduled into a scoreboard and checked on their due edge.
module tb_int_ctrl_gen;
    localparam int N = 13;

    logic           clk = 1'b0;
    logic           res_n;
    logic [N-1:0]   in_raw, int_ena, int_clr, int_set;
    logic [2*N-1:0] int_mode;
    logic [N-1:0]   int_sts, in_level;
    logic [4:0]     int_id;
    logic           int_any, interrupt;

    always #5 clk = ~clk;

    int_ctrl_gen #(.N_IN(N), .SYNC_STAGES(2), .DEB_CYCLES(4), .ID_W(5)) dut (
        .clk(clk), .res_n(res_n), .in_raw(in_raw), .int_ena(int_ena), .int_mode(int_mode),
        .int_clr(int_clr), .int_set(int_set), .int_sts(int_sts), .in_level(in_level),
        .int_id(int_id), .int_any(int_any), .interrupt(interrupt)
    );

    typedef struct {
        int          due;
        string       name;
        logic [N-1:0] sts;
        logic        intr;
        logic        chk_lvl;
        logic [N-1:0] lvl;
    } exp_t;

    typedef struct {
        int       ch;
        logic [1:0] mode;
        logic     start;
        logic     fin;
        logic     set;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [4:0] lowest(input logic [N-1:0] s);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) if (s[i]) lowest = 5'(i);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic expect_at(input int d, input string nm, input logic [N-1:0] s, input logic ir);
        exp_t e;
        e.due = cyc + d; e.name = nm; e.sts = s; e.intr = ir; e.chk_lvl = 1'b0; e.lvl = '0;
        sb.push_back(e);
    endtask

    task automatic expect_lvl(input int d, input string nm, input logic [N-1:0] s, input logic ir,
                              input logic [N-1:0] lv);
        exp_t e;
        e.due = cyc + d; e.name = nm; e.sts = s; e.intr = ir; e.chk_lvl = 1'b1; e.lvl = lv;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due < cyc) begin
                cmp({sb[k].name, " overdue"}, 32'(sb[k].due), 32'(cyc));
                sb.delete(k);
            end else if (sb[k].due == cyc) begin
                cmp({sb[k].name, " sts"}, 32'(int_sts), 32'(sb[k].sts));
                cmp({sb[k].name, " interrupt"}, 32'(interrupt), 32'(sb[k].intr));
                cmp({sb[k].name, " int_id"}, 32'(int_id), 32'(lowest(sb[k].sts)));
                cmp({sb[k].name, " int_any"}, 32'(int_any), 32'(sb[k].sts != '0));
                if (sb[k].chk_lvl) cmp({sb[k].name, " in_level"}, 32'(in_level), 32'(sb[k].lvl));
                $display("[cyc %0d] %s: sts=%h int=%0b id=%0d lvl=%h", cyc, sb[k].name,
                         int_sts, interrupt, int_id, in_level);
                sb.delete(k);
            end
        end
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        expect_lvl(1, "reset", '0, 1'b0, '0);
        tick();
        res_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [N-1:0] bitv;
        tbl[0] = '{3,  2'b00, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{7,  2'b00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1,  2'b01, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8,  2'b01, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{10, 2'b10, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{11, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{12, 2'b11, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{0,  2'b11, 1'b0, 1'b0, 1'b0};

        res_n = 1'b0; in_raw = '0; int_ena = '1; int_clr = '0; int_set = '0; int_mode = '0;

        // Trigger modes: settle at start level, clear, then move to final level.
        for (int v = 0; v < 8; v++) begin
            in_raw = '0; int_mode = '0;
            do_reset();
            int_mode[2*tbl[v].ch +: 2] = tbl[v].mode;
            in_raw[tbl[v].ch] = tbl[v].start;
            ticks(12);
            int_clr = '1;
            expect_at(2, $sformatf("v%0d cleared", v), '0, 1'b0);
            tick();
            int_clr = '0;
            ticks(2);
            in_raw[tbl[v].ch] = tbl[v].fin;
            bitv = tbl[v].set ? (N'(1) << tbl[v].ch) : '0;
            expect_at(5, $sformatf("v%0d edge5", v), '0, 1'b0);
            expect_at(6, $sformatf("v%0d edge6", v), bitv, 1'b0);
            expect_at(7, $sformatf("v%0d edge7", v), bitv, tbl[v].set);
            ticks(8);
        end

        // Glitch of 3 cycles rejected; 4-cycle pulse accepted.
        in_raw = '0; int_mode = '0;
        do_reset();
        in_raw[0] = 1'b1;
        for (int d = 1; d <= 10; d++) expect_lvl(d, $sformatf("glitch d%0d", d), '0, 1'b0, '0);
        ticks(3);
        in_raw[0] = 1'b0;
        ticks(8);
        in_raw[0] = 1'b1;
        expect_lvl(5, "pulse4 pre", '0, 1'b0, '0);
        expect_lvl(6, "pulse4 accept", 13'h1, 1'b0, 13'h1);
        ticks(4);
        in_raw[0] = 1'b0;
        expect_lvl(6, "pulse4 release", 13'h1, 1'b1, '0);
        ticks(7);

        // Falling on ch1, then clear timing.
        in_raw = '0; int_mode = '0;
        do_reset();
        int_mode[3:2] = 2'b01;
        in_raw[1] = 1'b1;
        ticks(12);
        in_raw[1] = 1'b0;
        ticks(8);
        int_clr[1] = 1'b1;
        expect_at(1, "ch1 clr sts", '0, 1'b1);
        expect_at(2, "ch1 clr int", '0, 1'b0);
        tick();
        int_clr = '0;
        ticks(2);

        // Level mode on ch2: clear while high drops for one cycle.
        in_raw = '0; int_mode = '0;
        do_reset();
        int_mode[5:4] = 2'b11;
        in_raw[2] = 1'b1;
        ticks(10);
        int_clr[2] = 1'b1;
        expect_at(1, "lvl clr", '0, 1'b1);
        expect_at(2, "lvl reset", 13'h4, 1'b0);
        expect_at(3, "lvl hold", 13'h4, 1'b1);
        tick();
        int_clr = '0;
        ticks(3);
        in_raw[2] = 1'b0;
        ticks(10);
        int_clr[2] = 1'b1;
        expect_at(1, "lvl low clr", '0, 1'b1);
        expect_at(3, "lvl low stays", '0, 1'b0);
        tick();
        int_clr = '0;
        ticks(3);

        // Set beats clear; disable wipes and masks ch4.
        in_raw = '0; int_mode = '0;
        do_reset();
        int_set[4] = 1'b1; int_clr[4] = 1'b1;
        expect_at(1, "set+clr", 13'h10, 1'b0);
        expect_at(2, "set+clr int", 13'h10, 1'b1);
        tick();
        int_set = '0; int_clr = '0;
        tick();
        int_ena[4] = 1'b0;
        expect_at(1, "ena off", '0, 1'b1);
        expect_at(2, "ena off int", '0, 1'b0);
        tick();
        in_raw[4] = 1'b1;
        int_set[4] = 1'b1;
        expect_at(1, "ena off set", '0, 1'b0);
        expect_at(7, "ena off edge", '0, 1'b0);
        tick();
        int_set = '0;
        ticks(9);
        int_ena[4] = 1'b1;
        expect_at(2, "ena back", '0, 1'b0);
        ticks(3);

        // Priority id, then reset mid-debounce with status pending.
        in_raw = '0; int_mode = '0;
        do_reset();
        int_set[5] = 1'b1; int_set[9] = 1'b1;
        expect_at(1, "ch5+ch9", 13'h220, 1'b0);
        tick();
        int_set = '0;
        tick();
        int_clr[5] = 1'b1;
        expect_at(1, "clr ch5", 13'h200, 1'b1);
        tick();
        int_clr = '0;
        in_raw[3] = 1'b1;
        ticks(4);
        do_reset();
        in_raw[3] = 1'b0;
        expect_lvl(8, "post reset", '0, 1'b0, '0);
        ticks(10);

        if (sb.size() != 0) cmp("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
